// File: rtl/kuznechik_key_expand.sv
// Kuznechik (GOST R 34.12-2015) key schedule: expands a 256-bit master key into ten
// 128-bit round keys using a byte-serial L step shared by constant and round-key generation.
module kuznechik_key_expand (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         keys_valid_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_C_LOAD, ST_C_L, ST_X, ST_S, ST_L, ST_F, ST_DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // L_COEF[i] multiplies byte i of the register (byte 0 = bits [7:0])
  localparam logic [7:0] L_COEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  // GF(2^8) product modulo x^8+x^7+x^6+x+1; with a constant operand this folds to XORs
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   a1_q, a0_q, c_q, t_q;
  logic [5:0]     iter_q;
  logic [3:0]     cnt_q;
  logic [127:0]   slot_q [10];
  logic           keys_valid_q;
  logic [127:0]   rd_key_q;

  logic [127:0]   l_in, l_out, s_out;
  logic [7:0]     l_sum;
  logic [3:0]     slot_even, slot_odd;

  assign busy_o       = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign keys_valid_o = keys_valid_q;
  assign rd_key_o     = rd_key_q;
  assign slot_even    = {iter_q[5:3], 1'b0};
  assign slot_odd     = {iter_q[5:3], 1'b1};

  // One L step: the constant register and the round register share a single unit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    l_in  = (state_q == ST_C_L) ? c_q : t_q;
    l_sum = '0;
    for (int i = 0; i < 16; i++) begin
      // NOTE: blocking '=' in combinational logic so the running XOR accumulates in order.
      l_sum = l_sum ^ gf_mul(l_in[8*i +: 8], L_COEF[i]);
    end
    l_out = {l_sum, l_in[127:8]};
  end

  always_comb begin
    s_out = '0;
    for (int i = 0; i < 16; i++) begin
      s_out[8*i +: 8] = SBOX[t_q[8*i +: 8]];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = ST_C_LOAD;
      ST_C_LOAD:        state_d = ST_C_L;
      ST_C_L:           if (cnt_q == 4'd15) state_d = ST_X;
      ST_X:             state_d = ST_S;
      ST_S:             state_d = ST_L;
      ST_L:             if (cnt_q == 4'd15) state_d = ST_F;
      ST_F:             state_d = (iter_q == 6'd32) ? ST_DONE : ST_C_LOAD;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
    if (!resetn_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      a1_q         <= '0;
      a0_q         <= '0;
      c_q          <= '0;
      t_q          <= '0;
      iter_q       <= '0;
      cnt_q        <= '0;
      keys_valid_q <= 1'b0;
      rd_key_q     <= '0;
      // NOTE: the key store is a small register file, cleared explicitly so an aborted run leaves nothing behind.
      for (int i = 0; i < 10; i++) slot_q[i] <= '0;
    end else begin
      rd_key_q <= (rd_idx_i < 4'd10) ? slot_q[rd_idx_i] : '0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            a1_q         <= key_i[255:128];
            a0_q         <= key_i[127:0];
            slot_q[0]    <= key_i[255:128];
            slot_q[1]    <= key_i[127:0];
            iter_q       <= 6'd1;
            keys_valid_q <= 1'b0;
          end
        end
        ST_C_LOAD: begin
          c_q   <= {122'b0, iter_q};
          cnt_q <= '0;
        end
        ST_C_L: begin
          c_q   <= l_out;
          cnt_q <= cnt_q + 4'd1;
        end
        ST_X: t_q <= a1_q ^ c_q;
        ST_S: begin
          t_q   <= s_out;
          cnt_q <= '0;
        end
        ST_L: begin
          t_q   <= l_out;
          cnt_q <= cnt_q + 4'd1;
        end
        ST_F: begin
          a1_q <= t_q ^ a0_q;
          a0_q <= a1_q;
          // Every eighth Feistel round yields the next key pair.
          if (iter_q[2:0] == 3'd0) begin
            slot_q[slot_even] <= t_q ^ a0_q;
            slot_q[slot_odd]  <= a1_q;
          end
          if (iter_q == 6'd32) keys_valid_q <= 1'b1;
          else                 iter_q       <= iter_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kuznechik_key_expand.sv
// Self-checking bench for kuznechik_key_expand: directed key vectors, read-port scoreboard
// and an independent byte-array software model of the key schedule.
module tb_kuznechik_key_expand;

  logic         clk_i = 1'b0;
  logic         resetn_i;
  logic         start_i;
  logic [255:0] key_i;
  logic         busy_o;
  logic         keys_valid_o;
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_key_o;

  kuznechik_key_expand dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .start_i      (start_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .keys_valid_o (keys_valid_o),
    .rd_idx_i     (rd_idx_i),
    .rd_key_o     (rd_key_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [255:0] KEY1  = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY_X = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00123456789abcdeffedcba9876543210;
  localparam logic [127:0] C1    = 128'h6ea276726c487ab85d27bd10dd849401;
  localparam logic [127:0] KREF [10] = '{
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Coefficients in standard order: index 0 multiplies the most significant byte.
  localparam logic [7:0] LSTD [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int unsigned t0;
  logic [127:0] mk [10];

  typedef struct {
    string        name;
    logic [127:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q [$];
  logic    rd_req   = 1'b0;
  logic    rd_req_d = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) rd_req_d <= rd_req;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one registered read result per request issued on the previous cycle.
  always @(negedge clk_i) begin
    if (rd_req_d) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_read", 128'd1, 128'd0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check(e.name, rd_key_o, e.exp);
      end
    end
  end

  // Polynomial product followed by explicit reduction by x^8+x^7+x^6+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h1C3 << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_l(input logic [127:0] v);
    logic [7:0]   x [16];
    logic [7:0]   l;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) x[k] = v[127 - 8*k -: 8];
    for (int n = 0; n < 16; n++) begin
      l = '0;
      for (int k = 0; k < 16; k++) l ^= gmul(x[k], LSTD[k]);
      for (int k = 15; k > 0; k--) x[k] = x[k-1];
      x[0] = l;
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = x[k];
    return r;
  endfunction

  function automatic logic [127:0] model_s(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = PI[v[8*k +: 8]];
    return r;
  endfunction

  function automatic void model_keys(input logic [255:0] key);
    logic [127:0] a1, a0, n;
    a1 = key[255:128];
    a0 = key[127:0];
    mk[0] = a1;
    mk[1] = a0;
    for (int i = 1; i <= 32; i++) begin
      n  = model_l(model_s(a1 ^ model_l(128'(i)))) ^ a0;
      a0 = a1;
      a1 = n;
      if (i % 8 == 0) begin
        mk[2*(i/8)]   = a1;
        mk[2*(i/8)+1] = a0;
      end
    end
  endfunction

  task automatic start_key(input logic [255:0] k, output int unsigned t_start);
    @(negedge clk_i);
    start_i = 1'b1;
    key_i   = k;
    @(negedge clk_i);
    start_i = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_until(input int unsigned t_start, input int unsigned n);
    while (cyc - t_start < n) @(negedge clk_i);
  endtask

  task automatic wait_done(input int unsigned t_start, input string name);
    while (!keys_valid_o && (cyc - t_start) < 3000) @(negedge clk_i);
    check({name, "_done_edge"}, 128'(cyc - t_start), 128'd1152);
    check({name, "_busy_after"}, 128'(busy_o), 128'd0);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    rd_idx_i = idx;
    rd_req   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_i);
    rd_req = 1'b0;
  endtask

  task automatic read_ref(input string pfx);
    for (int i = 0; i < 10; i++) rd(4'(i), KREF[i], $sformatf("%s_k%0d", pfx, i + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn_i = 1'b0;
    start_i  = 1'b0;
    key_i    = '0;
    rd_idx_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_valid", 128'(keys_valid_o), 128'd0);
    check("rst_rd_key", rd_key_o, 128'd0);
    resetn_i = 1'b1;
    rd(4'd0, 128'd0, "rst_slot0");
    rd(4'd9, 128'd0, "rst_slot9");

    // GOST reference key, with a probe of the first round constant
    start_key(KEY1, t0);
    check("t1_busy", 128'(busy_o), 128'd1);
    wait_until(t0, 17);
    check("t2_c1", dut.c_q, C1);
    wait_done(t0, "t1");
    read_ref("t1");

    // A start pulse mid-run must be ignored
    start_key(KEY1, t0);
    wait_until(t0, 499);
    start_i = 1'b1;
    key_i   = KEY_X;
    @(negedge clk_i);
    start_i = 1'b0;
    check("t3_busy", 128'(busy_o), 128'd1);
    wait_done(t0, "t3");
    read_ref("t3");

    // Reset mid-run clears state and key slots
    start_key(KEY1, t0);
    wait_until(t0, 700);
    resetn_i = 1'b0;
    rd(4'd2, 128'd0, "t4_rd_idx2");
    check("t4_busy", 128'(busy_o), 128'd0);
    check("t4_valid", 128'(keys_valid_o), 128'd0);
    resetn_i = 1'b1;
    rd(4'd3, 128'd0, "t4_slot3_cleared");
    start_key(KEY1, t0);
    wait_done(t0, "t4");
    read_ref("t4");

    // Out-of-range indices read as zero; back-to-back reads
    for (int i = 10; i < 16; i++) rd(4'(i), 128'd0, $sformatf("t6_idx%0d", i));
    rd(4'd0, KREF[0], "t6_b2b_k1");
    rd(4'd9, KREF[9], "t6_b2b_k10");

    // Restart from DONE with an all-zero key, checked against the software model
    check("t5_valid_pre", 128'(keys_valid_o), 128'd1);
    model_keys(256'd0);
    start_key(256'd0, t0);
    check("t5_valid_drop", 128'(keys_valid_o), 128'd0);
    check("t5_busy", 128'(busy_o), 128'd1);
    rd(4'd0, 128'd0, "t5_slot0");
    rd(4'd1, 128'd0, "t5_slot1");
    wait_done(t0, "t5");
    for (int i = 0; i < 10; i++) rd(4'(i), mk[i], $sformatf("t5_k%0d", i + 1));

    repeat (3) @(negedge clk_i);
    check("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
